// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: access FSM states, branch condition codes and
// control-word bit positions.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2,
        StDone = 2'd3
    } mem_state_e;

    typedef enum logic [1:0] {
        BrcEqz    = 2'd0,
        BrcNez    = 2'd1,
        BrcLtz    = 2'd2,
        BrcAlways = 2'd3
    } brc_e;

    // ctl_i = {regwr, memrd, memwr, mem2reg, mov, branch}
    localparam int unsigned CtlWidth   = 6;
    localparam int unsigned CtlBranch  = 0;
    localparam int unsigned CtlMov     = 1;
    localparam int unsigned CtlMem2Reg = 2;
    localparam int unsigned CtlMemWr   = 3;
    localparam int unsigned CtlMemRd   = 4;
    localparam int unsigned CtlRegWr   = 5;

    function automatic logic branch_cond(brc_e brc, logic is_zero, logic is_neg);
        logic taken;
        taken = 1'b0;
        unique case (brc)
            BrcEqz:    taken = is_zero;
            BrcNez:    taken = ~is_zero;
            BrcLtz:    taken = is_neg;
            BrcAlways: taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// Data-memory req/gnt/rvalid bus. The MEM stage is the master, the memory the slave.
interface mem_stage_hs_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
) ();

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_access_fsm.sv
// Memory access sequencer for the MEM stage: latches the access on acceptance,
// runs the req/gnt/rvalid handshake and hands the result to the WB register.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses stuck for TIMEOUT_CYC
// cycles in REQ/RESP; otherwise accesses wait indefinitely and err_o is tied low.
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned REG_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_op_i,
    input  logic                  write_i,
    input  logic                  regwr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [REG_WIDTH-1:0]  wreg_i,
    input  logic                  wb_stall_i,
    mem_stage_hs_if.master        dm,
    output logic                  idle_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [REG_WIDTH-1:0]  wreg_o,
    output logic                  regwr_o,
    output logic                  write_o,
    output logic                  err_o
);

    mem_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [REG_WIDTH-1:0]  wreg_q;
    logic                  regwr_q;
    logic                  write_q;
    logic                  capture;
    logic                  timeout_hit;

    // Read data arrives either with the grant (RESP skipped) or later in RESP.
    assign capture = dm.rvalid &
                     (((state_q == StReq) & dm.gnt & ~write_q) | (state_q == StResp));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Access latches: loaded only when a new access is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wreg_q  <= '0;
            regwr_q <= 1'b0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if ((state_q == StIdle) && mem_op_i) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                wreg_q  <= wreg_i;
                regwr_q <= regwr_i;
                write_q <= write_i;
            end
            if (capture) begin
                rdata_q <= dm.rdata;
            end
        end
    end

    // Next-state logic; handshake progress takes priority over a timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mem_op_i) state_d = StReq;
            end
            StReq: begin
                if (dm.gnt) begin
                    state_d = (write_q || dm.rvalid) ? StDone : StResp;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StResp: begin
                if (dm.rvalid) begin
                    state_d = StDone;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (!wb_stall_i) state_d = StIdle;
            end
        endcase
    end

    // Outputs: bus driven from the latches so address/data stay stable in REQ.
    always_comb begin
        dm.req   = (state_q == StReq);
        dm.we    = write_q;
        dm.addr  = addr_q;
        dm.wdata = wdata_q;
        idle_o   = (state_q == StIdle);
        done_o   = (state_q == StDone) & ~wb_stall_i;
        rdata_o  = rdata_q;
        wreg_o   = wreg_q;
        regwr_o  = regwr_q;
        write_o  = write_q;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            waiting;
    logic            err_q, err_d;

    assign waiting     = (state_q == StReq) || (state_q == StResp);
    assign timeout_hit = waiting && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    // Cycle counter for the wait in REQ/RESP and the abort pulse.
    always_comb begin
        cnt_d = waiting ? cnt_q + 1'b1 : '0;
        err_d = timeout_hit &
                ~(((state_q == StReq) & dm.gnt) | ((state_q == StResp) & dm.rvalid));
    end

    // Timeout counter and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign err_o          = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: branch resolution, EX forwarding, data-memory access via
// mem_access_fsm and the MEM/WB register.
// Optional feature: MEM_TIMEOUT_EN (access abort after TIMEOUT_CYC cycles).
module mem_stage_hs
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned IMM_WIDTH   = 8,
    parameter int unsigned REG_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] alu_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  fwd_sel_i,
    input  logic [DATA_WIDTH-1:0] res_w_i,
    input  logic [IMM_WIDTH-1:0]  imm_i,
    input  logic [REG_WIDTH-1:0]  wreg_i,
    input  logic [CtlWidth-1:0]   ctl_i,
    input  logic [1:0]            brc_i,
    input  logic                  flush_i,
    input  logic                  wb_stall_i,
    mem_stage_hs_if.master        dm,
    output logic                  stall_o,
    output logic                  pc_src_o,
    output logic [ADDR_WIDTH-1:0] br_addr_o,
    output logic [DATA_WIDTH-1:0] fwd_m_o,
    output logic                  wb_valid_o,
    output logic                  wb_regwr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [REG_WIDTH-1:0]  wb_reg_o,
    output logic                  err_o
);

    logic                  live;
    logic                  mem_op;
    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH-1:0] sext_imm_d;
    logic [ADDR_WIDTH-1:0] sext_imm_a;
    logic                  fsm_idle;
    logic                  fsm_done;
    logic [DATA_WIDTH-1:0] fsm_rdata;
    logic [REG_WIDTH-1:0]  fsm_wreg;
    logic                  fsm_regwr;
    logic                  fsm_write;
    logic                  unused_mem2reg;

    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_regwr_q, wb_regwr_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [REG_WIDTH-1:0]  wb_reg_q, wb_reg_d;

    // Loads always write back the memory data, so mem2reg carries no extra meaning here.
    assign unused_mem2reg = ctl_i[CtlMem2Reg];

    // Datapath: forwarding, branch target/condition and stall request.
    always_comb begin
        live       = in_valid_i & ~flush_i;
        mem_op     = live & (ctl_i[CtlMemRd] | ctl_i[CtlMemWr]);
        operand    = fwd_sel_i ? res_w_i : wdata_i;
        sext_imm_d = DATA_WIDTH'($signed(imm_i));
        sext_imm_a = ADDR_WIDTH'($signed(imm_i));
        fwd_m_o    = ctl_i[CtlMov] ? sext_imm_d : alu_i;
        br_addr_o  = pc_i + sext_imm_a;
        pc_src_o   = live & ctl_i[CtlBranch] &
                     branch_cond(brc_e'(brc_i), operand == '0, operand[DATA_WIDTH-1]);
        stall_o    = ~fsm_idle | mem_op;
    end

    mem_access_fsm #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .REG_WIDTH   (REG_WIDTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_op_i   (mem_op),
        .write_i    (ctl_i[CtlMemWr]),
        .regwr_i    (ctl_i[CtlRegWr]),
        .addr_i     (ADDR_WIDTH'(imm_i)),
        .wdata_i    (operand),
        .wreg_i     (wreg_i),
        .wb_stall_i (wb_stall_i),
        .dm         (dm),
        .idle_o     (fsm_idle),
        .done_o     (fsm_done),
        .rdata_o    (fsm_rdata),
        .wreg_o     (fsm_wreg),
        .regwr_o    (fsm_regwr),
        .write_o    (fsm_write),
        .err_o      (err_o)
    );

    // MEM/WB next value: completed access, pass-through op, or a bubble.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_regwr_d = 1'b0;
        wb_data_d  = '0;
        wb_reg_d   = '0;
        if (fsm_done) begin
            wb_valid_d = 1'b1;
            wb_regwr_d = fsm_regwr & ~fsm_write;
            wb_data_d  = fsm_write ? '0 : fsm_rdata;
            wb_reg_d   = fsm_wreg;
        end else if (fsm_idle && !mem_op) begin
            wb_valid_d = live;
            wb_regwr_d = live & ctl_i[CtlRegWr];
            wb_data_d  = fwd_m_o;
            wb_reg_d   = wreg_i;
        end
    end

    // MEM/WB register, frozen while WB stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_regwr_q <= 1'b0;
            wb_data_q  <= '0;
            wb_reg_q   <= '0;
        end else if (!wb_stall_i) begin
            wb_valid_q <= wb_valid_d;
            wb_regwr_q <= wb_regwr_d;
            wb_data_q  <= wb_data_d;
            wb_reg_q   <= wb_reg_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_regwr_o = wb_regwr_q;
    assign wb_data_o  = wb_data_q;
    assign wb_reg_o   = wb_reg_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs. Expected write-back results are queued when an
// instruction is issued and popped when wb_valid_o appears.
module tb_mem_stage_hs;
    import mem_stage_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned IW = 8;
    localparam int unsigned RW = 4;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [AW-1:0] pc;
    logic [DW-1:0] alu;
    logic [DW-1:0] wdata;
    logic          fwd_sel;
    logic [DW-1:0] res_w;
    logic [IW-1:0] imm;
    logic [RW-1:0] wreg;
    logic [5:0]    ctl;
    logic [1:0]    brc;
    logic          flush;
    logic          wb_stall;
    logic          stall_o, pc_src_o, wb_valid_o, wb_regwr_o, err_o;
    logic [AW-1:0] br_addr_o;
    logic [DW-1:0] fwd_m_o, wb_data_o;
    logic [RW-1:0] wb_reg_o;

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] rg;
        logic          regwr;
        bit            chk_data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_hs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dm_if ();

    mem_stage_hs #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .IMM_WIDTH   (IW),
        .REG_WIDTH   (RW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .pc_i       (pc),
        .alu_i      (alu),
        .wdata_i    (wdata),
        .fwd_sel_i  (fwd_sel),
        .res_w_i    (res_w),
        .imm_i      (imm),
        .wreg_i     (wreg),
        .ctl_i      (ctl),
        .brc_i      (brc),
        .flush_i    (flush),
        .wb_stall_i (wb_stall),
        .dm         (dm_if),
        .stall_o    (stall_o),
        .pc_src_o   (pc_src_o),
        .br_addr_o  (br_addr_o),
        .fwd_m_o    (fwd_m_o),
        .wb_valid_o (wb_valid_o),
        .wb_regwr_o (wb_regwr_o),
        .wb_data_o  (wb_data_o),
        .wb_reg_o   (wb_reg_o),
        .err_o      (err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; pc = '0; alu = '0; wdata = '0; fwd_sel = 1'b0; res_w = '0;
        imm = '0; wreg = '0; ctl = '0; brc = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_stall = 1'b0;
        dm_if.gnt = 1'b0; dm_if.rvalid = 1'b1; dm_if.rdata = 16'hFFFF;
        idle_inputs();
        tick(); tick();
        checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got=%0b exp=0", wb_valid_o); end
        checks++; if (wb_data_o !== 16'h0) begin failures++; $display("FAIL rst_wb_data got=%h exp=0000", wb_data_o); end
        checks++; if (dm_if.req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", dm_if.req); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err_o); end
        rst = 1'b0;
        tick(); tick();
        // stale rvalid held across reset release must be ignored
        checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL stale_rvalid_wb got=%0b exp=0", wb_valid_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL stale_rvalid_stall got=%0b exp=0", stall_o); end
        dm_if.rvalid = 1'b0;
        tick();
    endtask

    task automatic test_alu_mov();
        wb_exp_t e;
        in_valid = 1'b1; ctl = 6'b100000; alu = 16'h1234; wreg = 4'd3;
        exp_q.push_back('{16'h1234, 4'd3, 1'b1, 1'b1});
        #1;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0b exp=0", stall_o); end
        checks++; if (fwd_m_o !== 16'h1234) begin failures++; $display("FAIL alu_fwd got=%h exp=1234", fwd_m_o); end
        tick();
        in_valid = 1'b1; ctl = 6'b100010; alu = 16'h5555; imm = 8'hF0; wreg = 4'd7;
        checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL alu_wb_valid got=%0b exp=1", wb_valid_o); end
        e = exp_q.pop_front();
        checks++; if (wb_data_o !== e.data) begin failures++; $display("FAIL alu_wb_data got=%h exp=%h", wb_data_o, e.data); end
        checks++; if (wb_reg_o !== e.rg || wb_regwr_o !== e.regwr) begin failures++; $display("FAIL alu_wb_reg got=%0d/%0b exp=%0d/%0b", wb_reg_o, wb_regwr_o, e.rg, e.regwr); end
        exp_q.push_back('{16'hFFF0, 4'd7, 1'b1, 1'b1});
        #1;
        checks++; if (fwd_m_o !== 16'hFFF0) begin failures++; $display("FAIL mov_fwd got=%h exp=fff0", fwd_m_o); end
        tick();
        idle_inputs();
        checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL mov_wb_valid got=%0b exp=1", wb_valid_o); end
        e = exp_q.pop_front();
        checks++; if (wb_data_o !== e.data || wb_reg_o !== e.rg) begin failures++; $display("FAIL mov_wb_data got=%h/%0d exp=%h/%0d", wb_data_o, wb_reg_o, e.data, e.rg); end
        tick();
    endtask

    task automatic test_load();
        wb_exp_t e;
        in_valid = 1'b1; ctl = 6'b110100; imm = 8'h10; wreg = 4'd5; alu = 16'h7777;
        exp_q.push_back('{16'hBEEF, 4'd5, 1'b1, 1'b1});
        #1;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL ld_stall_idle got=%0b exp=1", stall_o); end
        tick();
        idle_inputs(); imm = 8'h99;
        for (int i = 0; i < 2; i++) begin
            checks++; if (stall_o !== 1'b1 || dm_if.req !== 1'b1 || dm_if.we !== 1'b0) begin failures++; $display("FAIL ld_req_cyc%0d got=%0b%0b%0b exp=110", i, stall_o, dm_if.req, dm_if.we); end
            checks++; if (dm_if.addr !== 8'h10) begin failures++; $display("FAIL ld_addr_cyc%0d got=%h exp=10", i, dm_if.addr); end
            if (i == 1) dm_if.gnt = 1'b1;
            tick();
        end
        dm_if.gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall_o !== 1'b1 || dm_if.req !== 1'b0 || dm_if.addr !== 8'h10) begin failures++; $display("FAIL ld_resp_cyc%0d got=%0b%0b/%h exp=10/10", i, stall_o, dm_if.req, dm_if.addr); end
            if (i == 2) begin dm_if.rvalid = 1'b1; dm_if.rdata = 16'hBEEF; end
            tick();
        end
        dm_if.rvalid = 1'b0; dm_if.rdata = 16'h0;
        checks++; if (stall_o !== 1'b1 || wb_valid_o !== 1'b0) begin failures++; $display("FAIL ld_done got=%0b%0b exp=10", stall_o, wb_valid_o); end
        tick();
        checks++; if (wb_valid_o !== 1'b1 || stall_o !== 1'b0) begin failures++; $display("FAIL ld_retire got=%0b%0b exp=10", wb_valid_o, stall_o); end
        e = exp_q.pop_front();
        checks++; if (wb_data_o !== e.data || wb_reg_o !== e.rg || wb_regwr_o !== e.regwr) begin failures++; $display("FAIL ld_wb got=%h/%0d/%0b exp=%h/%0d/%0b", wb_data_o, wb_reg_o, wb_regwr_o, e.data, e.rg, e.regwr); end
        tick();
    endtask

    task automatic test_load_same_cycle_wb_stall();
        wb_exp_t e;
        in_valid = 1'b1; ctl = 6'b110100; imm = 8'h30; wreg = 4'd9;
        exp_q.push_back('{16'hCAFE, 4'd9, 1'b1, 1'b1});
        tick();
        idle_inputs();
        dm_if.gnt = 1'b1; dm_if.rvalid = 1'b1; dm_if.rdata = 16'hCAFE;
        checks++; if (dm_if.req !== 1'b1 || dm_if.addr !== 8'h30) begin failures++; $display("FAIL gr_req got=%0b/%h exp=1/30", dm_if.req, dm_if.addr); end
        tick();
        dm_if.gnt = 1'b0; dm_if.rvalid = 1'b0; dm_if.rdata = 16'h0; wb_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (stall_o !== 1'b1 || wb_valid_o !== 1'b0) begin failures++; $display("FAIL gr_hold_cyc%0d got=%0b%0b exp=10", i, stall_o, wb_valid_o); end
            tick();
        end
        wb_stall = 1'b0;
        tick();
        checks++; if (wb_valid_o !== 1'b1 || stall_o !== 1'b0) begin failures++; $display("FAIL gr_retire got=%0b%0b exp=10", wb_valid_o, stall_o); end
        e = exp_q.pop_front();
        checks++; if (wb_data_o !== e.data || wb_reg_o !== e.rg) begin failures++; $display("FAIL gr_wb got=%h/%0d exp=%h/%0d", wb_data_o, wb_reg_o, e.data, e.rg); end
        tick();
    endtask

    task automatic test_store_fwd();
        wb_exp_t e;
        in_valid = 1'b1; ctl = 6'b001000; imm = 8'h20; wreg = 4'd2;
        fwd_sel = 1'b1; res_w = 16'h00AA; wdata = 16'h1111;
        exp_q.push_back('{16'h0, 4'd2, 1'b0, 1'b0});
        #1;
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL st_stall_idle got=%0b exp=1", stall_o); end
        tick();
        idle_inputs();
        checks++; if (dm_if.wdata !== 16'h00AA) begin failures++; $display("FAIL st_wdata got=%h exp=00aa", dm_if.wdata); end
        checks++; if (dm_if.we !== 1'b1 || dm_if.req !== 1'b1 || dm_if.addr !== 8'h20) begin failures++; $display("FAIL st_req got=%0b%0b/%h exp=11/20", dm_if.we, dm_if.req, dm_if.addr); end
        dm_if.gnt = 1'b1;
        tick();
        dm_if.gnt = 1'b0;
        checks++; if (dm_if.req !== 1'b0 || stall_o !== 1'b1) begin failures++; $display("FAIL st_done got=%0b%0b exp=01", dm_if.req, stall_o); end
        tick();
        checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL st_wb_valid got=%0b exp=1", wb_valid_o); end
        e = exp_q.pop_front();
        checks++; if (wb_regwr_o !== e.regwr || wb_reg_o !== e.rg || (e.chk_data && wb_data_o !== e.data)) begin failures++; $display("FAIL st_wb got=%0b/%0d exp=%0b/%0d", wb_regwr_o, wb_reg_o, e.regwr, e.rg); end
        tick();
    endtask

    task automatic test_branch();
        // brc, fwd_sel, wdata, res_w, flush, in_valid, pc, imm, exp taken, exp target
        logic [1:0]  t_brc[8]  = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1};
        logic        t_fwd[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] t_wd[8]   = '{16'h1, 16'h1, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h5};
        logic [15:0] t_rw[8]   = '{16'h0, 16'h0, 16'h9, 16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0};
        logic        t_fl[8]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        t_iv[8]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  t_pc[8]   = '{8'hF0, 8'hF0, 8'h10, 8'h10, 8'h10, 8'h00, 8'h80, 8'h00};
        logic [7:0]  t_imm[8]  = '{8'h20, 8'h20, 8'hF8, 8'h01, 8'h01, 8'h00, 8'h7F, 8'h00};
        logic        t_tk[8]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0]  t_tgt[8]  = '{8'h10, 8'h10, 8'h08, 8'h11, 8'h11, 8'h00, 8'hFF, 8'h00};
        for (int i = 0; i < 8; i++) begin
            ctl = 6'b000001; brc = t_brc[i]; fwd_sel = t_fwd[i]; wdata = t_wd[i];
            res_w = t_rw[i]; flush = t_fl[i]; in_valid = t_iv[i]; pc = t_pc[i]; imm = t_imm[i];
            #1;
            checks++; if (pc_src_o !== t_tk[i]) begin failures++; $display("FAIL br_taken_%0d got=%0b exp=%0b", i, pc_src_o, t_tk[i]); end
            checks++; if (br_addr_o !== t_tgt[i]) begin failures++; $display("FAIL br_addr_%0d got=%h exp=%h", i, br_addr_o, t_tgt[i]); end
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; flush = 1'b1; ctl = 6'b100000; alu = 16'h4321; wreg = 4'd1;
        tick();
        checks++; if (wb_valid_o !== 1'b0 || wb_regwr_o !== 1'b0) begin failures++; $display("FAIL flush_alu got=%0b%0b exp=00", wb_valid_o, wb_regwr_o); end
        ctl = 6'b110100; imm = 8'h44;
        #1;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL flush_ld_stall got=%0b exp=0", stall_o); end
        tick();
        idle_inputs();
        checks++; if (dm_if.req !== 1'b0 || wb_valid_o !== 1'b0) begin failures++; $display("FAIL flush_ld_req got=%0b%0b exp=00", dm_if.req, wb_valid_o); end
        tick();
    endtask

    task automatic test_reset_in_resp();
        in_valid = 1'b1; ctl = 6'b110100; imm = 8'h50; wreg = 4'd4;
        tick();
        idle_inputs();
        dm_if.gnt = 1'b1;
        tick();
        dm_if.gnt = 1'b0;
        checks++; if (dm_if.req !== 1'b0 || stall_o !== 1'b1) begin failures++; $display("FAIL rr_in_resp got=%0b%0b exp=01", dm_if.req, stall_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dm_if.rvalid = 1'b1; dm_if.rdata = 16'hDEAD;
        tick();
        dm_if.rvalid = 1'b0; dm_if.rdata = 16'h0;
        checks++; if (dm_if.req !== 1'b0 || stall_o !== 1'b0 || wb_valid_o !== 1'b0) begin failures++; $display("FAIL rr_after got=%0b%0b%0b exp=000", dm_if.req, stall_o, wb_valid_o); end
        tick();
        checks++; if (wb_valid_o !== 1'b0 || wb_data_o !== 16'h0) begin failures++; $display("FAIL rr_late got=%0b/%h exp=0/0000", wb_valid_o, wb_data_o); end
    endtask

    task automatic test_timeout();
        int errs = 0;
        int err_at = -1;
        bit wb_seen = 1'b0;
        in_valid = 1'b1; ctl = 6'b001000; imm = 8'h40; wdata = 16'h0101;
        tick();
        idle_inputs();
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            if (err_o === 1'b1) begin errs++; if (err_at < 0) err_at = i; end
            if (wb_valid_o !== 1'b0) wb_seen = 1'b1;
            tick();
        end
        checks++; if (errs != 1) begin failures++; $display("FAIL to_err_count got=%0d exp=1", errs); end
        checks++; if (err_at != int'(TO)) begin failures++; $display("FAIL to_err_cycle got=%0d exp=%0d", err_at, TO); end
        checks++; if (stall_o !== 1'b0 || dm_if.req !== 1'b0) begin failures++; $display("FAIL to_release got=%0b%0b exp=00", stall_o, dm_if.req); end
        checks++; if (wb_seen) begin failures++; $display("FAIL to_wb_valid got=1 exp=0"); end
        dm_if.rvalid = 1'b1; dm_if.rdata = 16'h5A5A;
        tick();
        dm_if.rvalid = 1'b0;
        tick();
        checks++; if (wb_valid_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL to_late_rvalid got=%0b%0b exp=00", wb_valid_o, stall_o); end
`else
        for (int i = 0; i < 10; i++) begin
            if (err_o !== 1'b0) errs++;
            if (stall_o !== 1'b1 || dm_if.req !== 1'b1) wb_seen = 1'b1;
            tick();
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL nto_err got=%0d exp=0", errs); end
        checks++; if (wb_seen) begin failures++; $display("FAIL nto_wait got=dropped exp=held"); end
        dm_if.gnt = 1'b1;
        tick();
        dm_if.gnt = 1'b0;
        tick();
        checks++; if (wb_valid_o !== 1'b1 || wb_regwr_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL nto_retire got=%0b%0b%0b exp=100", wb_valid_o, wb_regwr_o, stall_o); end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_mov();
        test_load();
        test_load_same_cycle_wb_stall();
        test_store_fwd();
        test_branch();
        test_flush();
        test_reset_in_resp();
        test_timeout();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
